memory_access_stage: RTL and testbench
======================================

Name: memory_access_stage

Overview:
- MEM stage of the 5-stage RISC-V pipeline; consumes the EX/MEM register fields and produces the MEM/WB register.
- Issues load/store requests to data memory over a req/gnt + rvalid handshake.
- Formats load data (sign/zero extension) and store data/byte strobes.
- Drives busywait_o to freeze upstream stages while an access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles in WAIT before the access is abandoned (8-bit counter, 1..255).

Ports:
- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  synchronous active-high reset
- reg_wb_en_ex_mem_i  input  1  writeback enable from EX/MEM
- rd_ex_mem_i  input  5  destination register label
- pc_ex_mem_i  input  32  instruction PC
- wb_sel_ex_mem_i  input  2  writeback source select, passed through
- alu_out_ex_mem_i  input  32  ALU result / effective address
- rs2_ex_mem_i  input  32  store data (already forwarded)
- funct3_ex_mem_i  input  3  access size/sign
- is_load_instr_ex_mem_i  input  1  load in EX/MEM
- is_store_instr_ex_mem_i  input  1  store in EX/MEM
- dmem_req_o  output  1  request valid
- dmem_gnt_i  input  1  request accepted
- dmem_we_o  output  1  1=store
- dmem_addr_o  output  32  word-aligned address {addr[31:2],2'b00}
- dmem_wdata_o  output  32  lane-replicated store data
- dmem_wstrb_o  output  4  byte strobes (0 for loads)
- dmem_rvalid_i  input  1  response valid (loads and stores)
- dmem_rdata_i  input  32  read word
- busywait_o  output  1  stall upstream
- bus_err_o  output  1  one-cycle pulse on timeout
- reg_wb_en_mem_wb_o  output  1  MEM/WB writeback enable
- rd_mem_wb_o  output  5  MEM/WB rd
- pc_mem_wb_o  output  32  MEM/WB PC
- wb_sel_mem_wb_o  output  2  MEM/WB wb select
- alu_out_mem_wb_o  output  32  MEM/WB ALU result
- rd_data_mem_wb_o  output  32  MEM/WB formatted load data
- is_memory_instruction_mem_wb_o  output  1  MEM/WB holds a load

Behaviour:
- Reset: state=IDLE, timeout counter=0, every registered output=0, dmem_req_o=0, bus_err_o=0.
- mem_op = is_load | is_store.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - If mem_op: assert dmem_req_o combinationally.
  - If dmem_gnt_i is high the same cycle, go to WAIT; otherwise go to REQ.
- REQ:
  - Hold dmem_req_o and all dmem_* outputs stable until dmem_gnt_i, then go to WAIT.
- WAIT:
  - dmem_req_o=0; count cycles.
  - On dmem_rvalid_i: load MEM/WB with the formatted data and go to IDLE.
  - A new mem_op in the next cycle starts from IDLE (no back-to-back issue in the same cycle).
  - If the counter reaches TIMEOUT_CYCLES without rvalid: pulse bus_err_o, write a MEM/WB bubble (reg_wb_en=0), go to IDLE.
  - If rvalid and timeout occur in the same cycle, rvalid wins.
- busywait_o = mem_op & ~(state==WAIT & (dmem_rvalid_i | timeout)). Combinational; EX/MEM inputs are held stable by upstream while it is high.
- MEM/WB register:
  - Non-memory op: updates every cycle, 1-cycle latency, rd_data_mem_wb_o=0.
  - Memory op: updates only on the completion cycle.
  - While busywait_o is high, reg_wb_en_mem_wb_o and is_memory_instruction_mem_wb_o are 0 (bubble); other fields hold their value.
- Store writeback: is_memory_instruction_mem_wb_o=0; reg_wb_en follows the input (normally 0).
- Store formatting, off = addr[1:0]:
  - SB (000): wdata = {4{rs2[7:0]}}, wstrb = 4'b0001 << off.
  - SH (001): wdata = {2{rs2[15:0]}}, wstrb = 4'b0011 << {off[1],1'b0}.
  - SW (010): wdata = rs2, wstrb = 4'b1111.
  - Any other funct3: wstrb = 0, access still handshaked.
- Load formatting:
  - Select byte off / halfword off[1] from rdata.
  - LB (000) and LH (001) sign-extend; LBU (100) and LHU (101) zero-extend; LW (010) uses the full word.
  - Any other funct3: 0.
- Misalignment (no macro): low address bits are used only for lane selection; there is no fault.
- Reset mid-transaction: return to IDLE immediately; an rvalid arriving in IDLE is ignored.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign_o (1 bit, registered with MEM/WB, reset 0).
  - Halfword with addr[0]=1, or word with addr[1:0]!=0, issues no request and writes a MEM/WB bubble with misalign_o=1.
  - busywait_o stays 0 for that op.
- Undefined: the port is absent, and misaligned accesses behave as described above.

Test Plan:
- Reset mid-WAIT on a load -> next cycle: state IDLE, dmem_req_o=0, busywait_o=0, all MEM/WB outputs 0; a late rvalid produces no writeback.
- LB at addr 0x1003 with rdata=0x80FF_1234 -> dmem_addr_o=0x1000, rd_data_mem_wb_o=0xFFFF_FF80, reg_wb_en_mem_wb_o=1 the cycle after rvalid.
- SH rs2=0x0000_ABCD at addr 0x2002, gnt delayed 3 cycles -> dmem_req_o held 4 cycles with wdata=0xABCD_ABCD, wstrb=4'b1100; busywait_o high until rvalid.
- ADD result 0x55 followed immediately by LW (gnt same cycle, rvalid 2 cycles later) -> MEM/WB alu_out=0x55 with 1-cycle latency, then two bubble cycles, then the load data.
- Load with no rvalid, TIMEOUT_CYCLES=4 -> bus_err_o pulses at the 4th WAIT cycle, bubble written, busywait_o drops the same cycle.
- With MEM_MISALIGN_TRAP_EN, LW at 0x1001 -> dmem_req_o never asserted, misalign_o=1, reg_wb_en_mem_wb_o=0.

Source files
------------

// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - RISC-V MEM stage with req/gnt/rvalid data port; MEM_MISALIGN_TRAP_EN adds a misalignment trap
module memory_access_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        reg_wb_en_ex_mem_i,
  input  logic [4:0]  rd_ex_mem_i,
  input  logic [31:0] pc_ex_mem_i,
  input  logic [1:0]  wb_sel_ex_mem_i,
  input  logic [31:0] alu_out_ex_mem_i,
  input  logic [31:0] rs2_ex_mem_i,
  input  logic [2:0]  funct3_ex_mem_i,
  input  logic        is_load_instr_ex_mem_i,
  input  logic        is_store_instr_ex_mem_i,
  output logic        dmem_req_o,
  input  logic        dmem_gnt_i,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_wstrb_o,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        busywait_o,
  output logic        bus_err_o,
  output logic        reg_wb_en_mem_wb_o,
  output logic [4:0]  rd_mem_wb_o,
  output logic [31:0] pc_mem_wb_o,
  output logic [1:0]  wb_sel_mem_wb_o,
  output logic [31:0] alu_out_mem_wb_o,
  output logic [31:0] rd_data_mem_wb_o,
  output logic        is_memory_instruction_mem_wb_o
`ifdef MEM_MISALIGN_TRAP_EN
  , output logic      misalign_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        mem_op;
  logic        misaligned;
  logic        issue_op;
  logic        timeout;
  logic        done;
  logic [1:0]  off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign off    = alu_out_ex_mem_i[1:0];
  assign mem_op = is_load_instr_ex_mem_i | is_store_instr_ex_mem_i;

`ifdef MEM_MISALIGN_TRAP_EN
  // funct3[1:0] encodes size: 01 halfword, 10 word
  assign misaligned = mem_op &
                      (((funct3_ex_mem_i[1:0] == 2'b01) & off[0]) |
                       ((funct3_ex_mem_i[1:0] == 2'b10) & (off != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  assign issue_op   = mem_op & ~misaligned;
  assign timeout    = (state == S_WAIT) && (cnt == TO_LAST);
  assign done       = (state == S_WAIT) && (dmem_rvalid_i || timeout);
  assign busywait_o = issue_op & ~done;
  assign bus_err_o  = timeout & ~dmem_rvalid_i;

  assign dmem_req_o  = ((state == S_IDLE) & issue_op) | (state == S_REQ);
  assign dmem_we_o   = is_store_instr_ex_mem_i;
  assign dmem_addr_o = {alu_out_ex_mem_i[31:2], 2'b00};

  always_comb begin
    dmem_wdata_o = rs2_ex_mem_i;
    dmem_wstrb_o = 4'b0000;
    case (funct3_ex_mem_i)
      3'b000: begin
        dmem_wdata_o = {4{rs2_ex_mem_i[7:0]}};
        dmem_wstrb_o = 4'b0001 << off;
      end
      3'b001: begin
        dmem_wdata_o = {2{rs2_ex_mem_i[15:0]}};
        dmem_wstrb_o = 4'b0011 << {off[1], 1'b0};
      end
      3'b010:  dmem_wstrb_o = 4'b1111;
      default: dmem_wstrb_o = 4'b0000;
    endcase
    if (!is_store_instr_ex_mem_i) dmem_wstrb_o = 4'b0000;
  end

  always_comb begin
    case (off)
      2'd0:    ld_byte = dmem_rdata_i[7:0];
      2'd1:    ld_byte = dmem_rdata_i[15:8];
      2'd2:    ld_byte = dmem_rdata_i[23:16];
      default: ld_byte = dmem_rdata_i[31:24];
    endcase
    ld_half = off[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (funct3_ex_mem_i)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = dmem_rdata_i;
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      cnt   <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= 8'd0;
          if (issue_op) state <= dmem_gnt_i ? S_WAIT : S_REQ;
        end
        S_REQ: begin
          cnt <= 8'd0;
          if (dmem_gnt_i) state <= S_WAIT;
        end
        S_WAIT: begin
          if (dmem_rvalid_i || timeout) state <= S_IDLE;
          else cnt <= cnt + 8'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      reg_wb_en_mem_wb_o             <= 1'b0;
      rd_mem_wb_o                    <= 5'd0;
      pc_mem_wb_o                    <= 32'd0;
      wb_sel_mem_wb_o                <= 2'd0;
      alu_out_mem_wb_o               <= 32'd0;
      rd_data_mem_wb_o               <= 32'd0;
      is_memory_instruction_mem_wb_o <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_o                     <= 1'b0;
`endif
    end else if (done && dmem_rvalid_i) begin
      reg_wb_en_mem_wb_o             <= reg_wb_en_ex_mem_i;
      rd_mem_wb_o                    <= rd_ex_mem_i;
      pc_mem_wb_o                    <= pc_ex_mem_i;
      wb_sel_mem_wb_o                <= wb_sel_ex_mem_i;
      alu_out_mem_wb_o               <= alu_out_ex_mem_i;
      rd_data_mem_wb_o               <= is_load_instr_ex_mem_i ? ld_data : 32'd0;
      is_memory_instruction_mem_wb_o <= is_load_instr_ex_mem_i;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_o                     <= 1'b0;
`endif
    end else if (done || busywait_o) begin
      // Bubble: timeout or access still outstanding
      reg_wb_en_mem_wb_o             <= 1'b0;
      is_memory_instruction_mem_wb_o <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_o                     <= 1'b0;
`endif
    end else begin
      reg_wb_en_mem_wb_o             <= reg_wb_en_ex_mem_i & ~misaligned;
      rd_mem_wb_o                    <= rd_ex_mem_i;
      pc_mem_wb_o                    <= pc_ex_mem_i;
      wb_sel_mem_wb_o                <= wb_sel_ex_mem_i;
      alu_out_mem_wb_o               <= alu_out_ex_mem_i;
      rd_data_mem_wb_o               <= 32'd0;
      is_memory_instruction_mem_wb_o <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_o                     <= misaligned;
`endif
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// tb/tb_memory_access_stage.sv - directed table-driven bench for memory_access_stage
module tb_memory_access_stage;

  logic        clk;
  logic        rst;
  logic        reg_wb_en;
  logic [4:0]  rd;
  logic [31:0] pc;
  logic [1:0]  wb_sel;
  logic [31:0] alu;
  logic [31:0] rs2;
  logic [2:0]  funct3;
  logic        is_load;
  logic        is_store;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        busywait;
  logic        bus_err;
  logic        wb_en_o;
  logic [4:0]  rd_o;
  logic [31:0] pc_o;
  logic [1:0]  wb_sel_o;
  logic [31:0] alu_o;
  logic [31:0] rd_data_o;
  logic        is_mem_o;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int n_pass  = 0;
  int n_total = 0;

  memory_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i                          (clk),
    .rst_i                          (rst),
    .reg_wb_en_ex_mem_i             (reg_wb_en),
    .rd_ex_mem_i                    (rd),
    .pc_ex_mem_i                    (pc),
    .wb_sel_ex_mem_i                (wb_sel),
    .alu_out_ex_mem_i               (alu),
    .rs2_ex_mem_i                   (rs2),
    .funct3_ex_mem_i                (funct3),
    .is_load_instr_ex_mem_i         (is_load),
    .is_store_instr_ex_mem_i        (is_store),
    .dmem_req_o                     (req),
    .dmem_gnt_i                     (gnt),
    .dmem_we_o                      (we),
    .dmem_addr_o                    (addr),
    .dmem_wdata_o                   (wdata),
    .dmem_wstrb_o                   (wstrb),
    .dmem_rvalid_i                  (rvalid),
    .dmem_rdata_i                   (rdata),
    .busywait_o                     (busywait),
    .bus_err_o                      (bus_err),
    .reg_wb_en_mem_wb_o             (wb_en_o),
    .rd_mem_wb_o                    (rd_o),
    .pc_mem_wb_o                    (pc_o),
    .wb_sel_mem_wb_o                (wb_sel_o),
    .alu_out_mem_wb_o               (alu_o),
    .rd_data_mem_wb_o               (rd_data_o),
    .is_memory_instruction_mem_wb_o (is_mem_o)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign_o                   (misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic        ld;
    logic [31:0] a;
    logic [31:0] sdata;
    logic [31:0] rword;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    logic        chk_wd;
    logic [31:0] e_rd_data;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reg_wb_en = 1'b0; rd = 5'd0; pc = 32'd0; wb_sel = 2'd0; alu = 32'd0;
    rs2 = 32'd0; funct3 = 3'd0; is_load = 1'b0; is_store = 1'b0;
    gnt = 1'b0; rvalid = 1'b0; rdata = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{3'b000, 1'b1, 32'h0000_1003, 32'h0, 32'h80FF_1234, 32'h0000_1000, 32'h0, 4'b0000, 1'b0, 32'hFFFF_FF80};
    tbl[1]  = '{3'b100, 1'b1, 32'h0000_1003, 32'h0, 32'h80FF_1234, 32'h0000_1000, 32'h0, 4'b0000, 1'b0, 32'h0000_0080};
    tbl[2]  = '{3'b001, 1'b1, 32'h0000_1002, 32'h0, 32'h80FF_1234, 32'h0000_1000, 32'h0, 4'b0000, 1'b0, 32'hFFFF_80FF};
    tbl[3]  = '{3'b101, 1'b1, 32'h0000_1000, 32'h0, 32'h80FF_9234, 32'h0000_1000, 32'h0, 4'b0000, 1'b0, 32'h0000_9234};
    tbl[4]  = '{3'b001, 1'b1, 32'h0000_1000, 32'h0, 32'h80FF_1234, 32'h0000_1000, 32'h0, 4'b0000, 1'b0, 32'h0000_1234};
    tbl[5]  = '{3'b010, 1'b1, 32'h0000_2004, 32'h0, 32'hDEAD_BEEF, 32'h0000_2004, 32'h0, 4'b0000, 1'b0, 32'hDEAD_BEEF};
    tbl[6]  = '{3'b011, 1'b1, 32'h0000_2008, 32'h0, 32'hDEAD_BEEF, 32'h0000_2008, 32'h0, 4'b0000, 1'b0, 32'h0000_0000};
    tbl[7]  = '{3'b000, 1'b1, 32'h0000_1001, 32'h0, 32'h80FF_1234, 32'h0000_1000, 32'h0, 4'b0000, 1'b0, 32'h0000_0012};
    tbl[8]  = '{3'b000, 1'b0, 32'h0000_3001, 32'h1122_33A5, 32'h0, 32'h0000_3000, 32'hA5A5_A5A5, 4'b0010, 1'b1, 32'h0};
    tbl[9]  = '{3'b001, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 32'h0000_2000, 32'hABCD_ABCD, 4'b1100, 1'b1, 32'h0};
    tbl[10] = '{3'b010, 1'b0, 32'h0000_3008, 32'h1234_5678, 32'h0, 32'h0000_3008, 32'h1234_5678, 4'b1111, 1'b1, 32'h0};
    tbl[11] = '{3'b011, 1'b0, 32'h0000_300C, 32'h1234_5678, 32'h0, 32'h0000_300C, 32'h0, 4'b0000, 1'b0, 32'h0};

    idle_inputs();
    rst = 1'b1;
    step();
    step();
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_busywait", {31'd0, busywait}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst_wb_en", {31'd0, wb_en_o}, 32'd0);
    chk("rst_is_mem", {31'd0, is_mem_o}, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_rd_data", rd_data_o, 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 12; i++) begin
      idle_inputs();
      pc        = 32'h100 + 32'(i) * 4;
      rd        = 5'(i + 1);
      reg_wb_en = tbl[i].ld;
      funct3    = tbl[i].f3;
      alu       = tbl[i].a;
      rs2       = tbl[i].sdata;
      is_load   = tbl[i].ld;
      is_store  = ~tbl[i].ld;
      gnt       = 1'b1;
      #1;
      chk($sformatf("v%0d_req", i), {31'd0, req}, 32'd1);
      chk($sformatf("v%0d_we", i), {31'd0, we}, {31'd0, ~tbl[i].ld});
      chk($sformatf("v%0d_addr", i), addr, tbl[i].e_addr);
      chk($sformatf("v%0d_wstrb", i), {28'd0, wstrb}, {28'd0, tbl[i].e_wstrb});
      if (tbl[i].chk_wd) chk($sformatf("v%0d_wdata", i), wdata, tbl[i].e_wdata);
      chk($sformatf("v%0d_busy_issue", i), {31'd0, busywait}, 32'd1);
      step();
      gnt    = 1'b0;
      rvalid = 1'b1;
      rdata  = tbl[i].rword;
      #1;
      chk($sformatf("v%0d_req_wait", i), {31'd0, req}, 32'd0);
      chk($sformatf("v%0d_busy_done", i), {31'd0, busywait}, 32'd0);
      step();
      idle_inputs();
      chk($sformatf("v%0d_rd_data", i), rd_data_o, tbl[i].e_rd_data);
      chk($sformatf("v%0d_wb_en", i), {31'd0, wb_en_o}, {31'd0, tbl[i].ld});
      chk($sformatf("v%0d_is_mem", i), {31'd0, is_mem_o}, {31'd0, tbl[i].ld});
      chk($sformatf("v%0d_rd", i), {27'd0, rd_o}, 32'(i + 1));
      chk($sformatf("v%0d_pc", i), pc_o, 32'h100 + 32'(i) * 4);
    end

    // ALU op followed immediately by a load
    idle_inputs();
    alu = 32'h55; reg_wb_en = 1'b1; rd = 5'd7; pc = 32'h200;
    step();
    chk("add_alu_out", alu_o, 32'h55);
    chk("add_wb_en", {31'd0, wb_en_o}, 32'd1);
    chk("add_rd_data", rd_data_o, 32'd0);
    funct3 = 3'b010; is_load = 1'b1; alu = 32'h4000; rd = 5'd8;
    pc = 32'h204; wb_sel = 2'b01; gnt = 1'b1;
    #1;
    chk("lw_busy", {31'd0, busywait}, 32'd1);
    step();
    gnt = 1'b0;
    chk("lw_bubble1_wb_en", {31'd0, wb_en_o}, 32'd0);
    chk("lw_bubble1_alu_hold", alu_o, 32'h55);
    step();
    rvalid = 1'b1; rdata = 32'hCAFE_F00D;
    chk("lw_bubble2_wb_en", {31'd0, wb_en_o}, 32'd0);
    step();
    idle_inputs();
    chk("lw_wb_en", {31'd0, wb_en_o}, 32'd1);
    chk("lw_rd_data", rd_data_o, 32'hCAFE_F00D);
    chk("lw_is_mem", {31'd0, is_mem_o}, 32'd1);
    chk("lw_alu_out", alu_o, 32'h4000);
    chk("lw_wb_sel", {30'd0, wb_sel_o}, 32'd1);

    // Store halfword with grant delayed three cycles
    idle_inputs();
    is_store = 1'b1; funct3 = 3'b001; alu = 32'h2002; rs2 = 32'h0000_ABCD;
    for (int k = 0; k < 4; k++) begin
      gnt = (k == 3);
      #1;
      chk($sformatf("sh_req_c%0d", k), {31'd0, req}, 32'd1);
      chk($sformatf("sh_wdata_c%0d", k), wdata, 32'hABCD_ABCD);
      chk($sformatf("sh_wstrb_c%0d", k), {28'd0, wstrb}, 32'hC);
      chk($sformatf("sh_busy_c%0d", k), {31'd0, busywait}, 32'd1);
      step();
    end
    gnt = 1'b0;
    #1;
    chk("sh_req_wait", {31'd0, req}, 32'd0);
    chk("sh_busy_wait", {31'd0, busywait}, 32'd1);
    step();
    rvalid = 1'b1;
    #1;
    chk("sh_busy_rvalid", {31'd0, busywait}, 32'd0);
    step();
    idle_inputs();
    chk("sh_is_mem", {31'd0, is_mem_o}, 32'd0);
    chk("sh_wb_en", {31'd0, wb_en_o}, 32'd0);

    // Load that never gets a response
    idle_inputs();
    is_load = 1'b1; funct3 = 3'b010; alu = 32'h5000; reg_wb_en = 1'b1; rd = 5'd9; gnt = 1'b1;
    step();
    gnt = 1'b0;
    for (int w = 1; w <= 4; w++) begin
      #1;
      chk($sformatf("to_bus_err_w%0d", w), {31'd0, bus_err}, {31'd0, (w == 4)});
      chk($sformatf("to_busy_w%0d", w), {31'd0, busywait}, {31'd0, (w != 4)});
      if (w < 4) step();
    end
    step();
    idle_inputs();
    #1;
    chk("to_wb_en", {31'd0, wb_en_o}, 32'd0);
    chk("to_is_mem", {31'd0, is_mem_o}, 32'd0);
    chk("to_bus_err_after", {31'd0, bus_err}, 32'd0);
    chk("to_req_after", {31'd0, req}, 32'd0);

    // Reset while waiting on a load
    idle_inputs();
    is_load = 1'b1; funct3 = 3'b010; alu = 32'h6000; reg_wb_en = 1'b1; rd = 5'd10;
    pc = 32'h300; gnt = 1'b1;
    step();
    gnt = 1'b0;
    step();
    rst = 1'b1;
    idle_inputs();
    step();
    chk("rstw_req", {31'd0, req}, 32'd0);
    chk("rstw_busy", {31'd0, busywait}, 32'd0);
    chk("rstw_wb_en", {31'd0, wb_en_o}, 32'd0);
    chk("rstw_pc", pc_o, 32'd0);
    chk("rstw_rd", {27'd0, rd_o}, 32'd0);
    chk("rstw_alu", alu_o, 32'd0);
    rst = 1'b0;
    rvalid = 1'b1; rdata = 32'h1234_5678;
    #1;
    chk("rstw_late_req", {31'd0, req}, 32'd0);
    step();
    rvalid = 1'b0;
    chk("rstw_late_wb_en", {31'd0, wb_en_o}, 32'd0);
    chk("rstw_late_rd_data", rd_data_o, 32'd0);
    chk("rstw_late_is_mem", {31'd0, is_mem_o}, 32'd0);

`ifdef MEM_MISALIGN_TRAP_EN
    idle_inputs();
    is_load = 1'b1; funct3 = 3'b010; alu = 32'h1001; reg_wb_en = 1'b1; rd = 5'd11;
    #1;
    chk("mis_req", {31'd0, req}, 32'd0);
    chk("mis_busy", {31'd0, busywait}, 32'd0);
    step();
    chk("mis_misalign", {31'd0, misalign}, 32'd1);
    chk("mis_wb_en", {31'd0, wb_en_o}, 32'd0);
    idle_inputs();
    step();
    chk("mis_clear", {31'd0, misalign}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
